// File: rtl/cursor_dir_ctrl_if.sv
// Cursor controller bus: button levels and edit-mode enables in, field address and blink qualifier out.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level, sampled or driven once per clock.
interface cursor_dir_ctrl_if;
  // Button levels, already synchronized and debounced
  logic       btn_izq;
  logic       btn_der;
  // Edit-mode enables; exactly one high selects a valid edit mode
  logic       en_cont_hora;
  logic       en_cont_fecha;
  logic       en_cont_timer;
  // Field address (0..2), blink qualifier, valid-mode flag
  logic [1:0] dir_bin;
  logic       cursor;
  logic       edit_active;

  // Source of buttons/modes, sink of cursor state
  modport master (
    output btn_izq, btn_der, en_cont_hora, en_cont_fecha, en_cont_timer,
    input  dir_bin, cursor, edit_active
  );

  // The controller itself
  modport slave (
    input  btn_izq, btn_der, en_cont_hora, en_cont_fecha, en_cont_timer,
    output dir_bin, cursor, edit_active
  );
endinterface

// File: rtl/cursor_dir_ctrl.sv
// Cursor-position controller: left/right presses move a 3-field address, plus a blinking cursor qualifier.
// Latency: a press sampled at one edge moves dir_bin at that same edge (one cycle after the level rises).
// No backpressure: presses arriving while no single edit mode is selected, or on mode entry, are dropped.
module cursor_dir_ctrl #(
  parameter int BLINK_DIV = 25_000_000,  // cycles per cursor half-period, >= 2
  parameter int CNT_W     = 25           // 2**CNT_W >= BLINK_DIV
) (
  input logic            clk,
  input logic            reset,
  cursor_dir_ctrl_if.slave bus
);

  localparam logic [1:0]       FIELD_FIRST = 2'd0;
  localparam logic [1:0]       FIELD_LAST  = 2'd2;
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Registered state
  logic [1:0]       dir_q;
  logic             cursor_q;
  logic             edit_q;
  logic [CNT_W-1:0] blink_cnt;
  logic [2:0]       mode_q;
  logic             izq_q;
  logic             der_q;

  // Combinational qualifiers
  logic [2:0] mode_vec;
  logic       mode_valid;
  logic       mode_change;
  logic       press_izq;
  logic       press_der;
  logic       press_both;
  logic       blink_wrap;
  logic [1:0] dir_next_right;
  logic [1:0] dir_next_left;

  assign mode_vec = {bus.en_cont_hora, bus.en_cont_fecha, bus.en_cont_timer};

  // Decode mode validity, entry/switch, button rising edges and field wrap targets
  always_comb begin
    mode_valid = 1'b0;
    case (mode_vec)
      3'b100, 3'b010, 3'b001: mode_valid = 1'b1;
      default:                mode_valid = 1'b0;
    endcase
    mode_change    = (mode_vec != mode_q);
    press_der      = bus.btn_der & ~der_q;
    press_izq      = bus.btn_izq & ~izq_q;
    press_both     = press_der & press_izq;
    blink_wrap     = (blink_cnt == BLINK_LAST);
    dir_next_right = (dir_q == FIELD_LAST)  ? FIELD_FIRST : dir_q + 2'd1;
    dir_next_left  = (dir_q == FIELD_FIRST) ? FIELD_LAST  : dir_q - 2'd1;
  end

  // Button history; loads 1 on reset so a button held through reset never counts as a press
  always_ff @(posedge clk) begin
    if (reset) begin
      izq_q <= 1'b1;
      der_q <= 1'b1;
    end else begin
      izq_q <= bus.btn_izq;
      der_q <= bus.btn_der;
    end
  end

  // Previous mode vector, used to spot mode entry and mode switches
  always_ff @(posedge clk) begin
    if (reset) mode_q <= 3'b000;
    else       mode_q <= mode_vec;
  end

  // Edit-active flag follows mode validity one cycle later
  always_ff @(posedge clk) begin
    if (reset) edit_q <= 1'b0;
    else       edit_q <= mode_valid;
  end

  // Field address: cleared when idle or on mode entry, otherwise moved by single presses with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= FIELD_FIRST;
    end else if (!mode_valid || mode_change) begin
      dir_q <= FIELD_FIRST;
    end else if (press_both) begin
      dir_q <= dir_q;
    end else if (press_der) begin
      dir_q <= dir_next_right;
    end else if (press_izq) begin
      dir_q <= dir_next_left;
    end
  end

  // Cursor qualifier: forced on after entry or a move so the selected field shows at once, else blinks
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_q <= 1'b0;
    end else if (!mode_valid) begin
      cursor_q <= 1'b0;
    end else if (mode_change) begin
      cursor_q <= 1'b1;
    end else if (!press_both && (press_der || press_izq)) begin
      cursor_q <= 1'b1;
    end else if (blink_wrap) begin
      cursor_q <= ~cursor_q;
    end
  end

  // Blink half-period counter; restarts whenever the cursor is forced on
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
    end else if (!mode_valid || mode_change) begin
      blink_cnt <= '0;
    end else if (!press_both && (press_der || press_izq)) begin
      blink_cnt <= '0;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + CNT_ONE;
    end
  end

  assign bus.dir_bin     = dir_q;
  assign bus.cursor      = cursor_q;
  assign bus.edit_active = edit_q;

endmodule
